gray_stretch_fb: RTL and testbench
==================================

GRAY_STRETCH_FB -- requirements
Module: gray_stretch_fb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter ADDRESS_WIDTH, default 8, frame length N = 2**ADDRESS_WIDTH pixels.
REQ-003 Parameter FRAC_BITS, default 8, fractional bits of the stretch gain.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 mode  in  2  0 bypass, 1 stretch, 2 stretch-inverted, 3 treated as 1; sampled per output frame.
REQ-007 in_data  in  DATA_WIDTH  input pixel.
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_ready  out  1  block accepts a pixel; transfer when in_valid && in_ready.
REQ-010 out_data  out  DATA_WIDTH  processed pixel.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_ready  in  1  sink accepts; transfer when out_valid && out_ready.
REQ-013 out_sof / out_eof  out  1 each  qualify first / last pixel of the output frame.
REQ-014 frame_min / frame_max  out  DATA_WIDTH each  statistics of the frame currently being output.

Function
REQ-015 Storage SHALL be two banks of N x DATA_WIDTH (ping-pong); writer fills one bank while reader streams the other.
REQ-016 Writer: each input transfer writes ram[wr_bank][wr_addr], increments wr_addr, updates running min/max.
REQ-017 On the transfer with wr_addr = N-1: wr_addr wraps to 0, full[wr_bank] set, running min/max latched into stats[wr_bank], accumulators reset (min to all-ones, max to 0), wr_bank toggles.
REQ-018 in_ready SHALL equal !full[wr_bank]; both banks full -> in_ready = 0 until reader releases one.
REQ-019 Reader FSM states IDLE, DIV, STREAM; IDLE -> DIV when full[rd_bank]; latches mode, stats[rd_bank] into frame_min/frame_max.
REQ-020 DIV SHALL run a sequential restoring divider for exactly DATA_WIDTH+FRAC_BITS cycles, then enter STREAM; DIV runs in all modes (fixed timing).
REQ-021 gain = floor(((2**DATA_WIDTH-1) << FRAC_BITS) / (max-min)), width DATA_WIDTH+FRAC_BITS; max = min -> gain unused (see REQ-024).
REQ-022 STREAM: 3-stage pipeline (RAM read, subtract/multiply, shift/clip); product width 2*DATA_WIDTH+FRAC_BITS; result = min(((p-min)*gain) >> FRAC_BITS, 2**DATA_WIDTH-1).
REQ-023 Mode 0 out = p; mode 1 out = result; mode 2 out = (2**DATA_WIDTH-1) - result.
REQ-024 Range zero (max = min) in mode 1 or 2: out = p unchanged.
REQ-025 Backpressure: while out_valid && !out_ready, all reader pipeline stages and address SHALL hold; out_data, out_sof, out_eof stable; no pixel lost or duplicated.
REQ-026 Latency from IDLE -> DIV transition to first out_valid SHALL be DATA_WIDTH+FRAC_BITS+3 cycles with out_ready high; thereafter one pixel per cycle.
REQ-027 On the out_eof transfer: full[rd_bank] cleared, rd_bank toggles, FSM -> IDLE; set and clear of opposite banks in the same cycle both take effect.
REQ-028 frame_min/frame_max SHALL hold their values until the next IDLE -> DIV transition.

Reset
REQ-029 rstn low at a posedge: FSM IDLE, both full flags 0, wr_bank = rd_bank = 0, wr_addr = 0, pipeline valids 0, accumulators min all-ones / max 0.
REQ-030 Outputs after reset: out_valid 0, out_sof 0, out_eof 0, out_data 0, frame_min 0, frame_max 0, in_ready 1.
REQ-031 Reset mid-frame SHALL discard partial input and all buffered frames; RAM contents need not be cleared.

Verification (DATA_WIDTH 8, ADDRESS_WIDTH 4, FRAC_BITS 8)
REQ-032 Mode 1, ramp 10..25, out_ready 1 -> gain 4352; out 0,17,34,...,255; frame_min 10, frame_max 25; out_sof on first, out_eof on 16th.
REQ-033 Mode 2, same ramp -> out 255,238,...,0.
REQ-034 Mode 1, constant 100 frame -> out 100 x16; frame_min = frame_max = 100.
REQ-035 Mode 0, random frame -> out equals input order; first out_valid exactly 19 cycles after DIV entry.
REQ-036 out_ready low 5 cycles mid-frame, input continuous -> out_data held, 16 unique pixels per frame; in_ready drops on pixel 33 until first output frame's out_eof transfer.
REQ-037 rstn low 1 cycle mid-STREAM -> next cycle out_valid 0, in_ready 1; next full frame output correctly per REQ-032.

Source files
------------

// File: rtl/gray_stretch_fb.sv
// Ping-pong frame buffer with per-frame contrast stretch.
// The writer fills one bank while tracking min/max. The reader takes the
// other bank, computes the stretch gain with a serial divider, and streams
// the frame through a three-stage pipeline that stalls under backpressure.
module gray_stretch_fb #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int FRAC_BITS     = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic [DATA_WIDTH-1:0] frame_min,
    output logic [DATA_WIDTH-1:0] frame_max
);

    localparam int N     = 2 ** ADDRESS_WIDTH;
    localparam int GW    = DATA_WIDTH + FRAC_BITS;      // gain / quotient width
    localparam int PW    = 2 * DATA_WIDTH + FRAC_BITS;  // product width
    localparam int CNT_W = $clog2(GW + 1);

    localparam logic [DATA_WIDTH-1:0]    PIX_MAX   = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]    PIX_ZERO  = {DATA_WIDTH{1'b0}};
    localparam logic [GW-1:0]            DIVIDEND  = {PIX_MAX, {FRAC_BITS{1'b0}}};
    localparam logic [GW-1:0]            GW_ZERO   = {GW{1'b0}};
    localparam logic [PW-1:0]            PW_ZERO   = {PW{1'b0}};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = {ADDRESS_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]         CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]         CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]         DIV_LAST  = CNT_W'(GW - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_STREAM = 2'd2
    } rd_state_e;

    // ------------------------------------------------------------------
    // Storage: bank select is the MSB of the RAM address
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [0:2*N-1];
    logic [DATA_WIDTH-1:0] ram_rd_q;

    // ------------------------------------------------------------------
    // Writer state
    // ------------------------------------------------------------------
    logic                     wr_bank_q;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q;
    logic [1:0]               full_q;
    logic [1:0]               full_d;
    logic [DATA_WIDTH-1:0]    acc_min_q;
    logic [DATA_WIDTH-1:0]    acc_max_q;
    logic [DATA_WIDTH-1:0]    stat_min_q [0:1];
    logic [DATA_WIDTH-1:0]    stat_max_q [0:1];

    logic                     in_ready_s;
    logic                     in_xfer_s;
    logic                     wr_last_s;
    logic [DATA_WIDTH-1:0]    pix_min_s;
    logic [DATA_WIDTH-1:0]    pix_max_s;

    // ------------------------------------------------------------------
    // Reader state
    // ------------------------------------------------------------------
    rd_state_e                state_q;
    logic                     rd_bank_q;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q;
    logic                     rd_done_q;
    logic [1:0]               mode_q;
    logic                     range_zero_q;
    logic [DATA_WIDTH-1:0]    frame_min_q;
    logic [DATA_WIDTH-1:0]    frame_max_q;

    logic [DATA_WIDTH-1:0]    div_den_q;
    logic [DATA_WIDTH-1:0]    div_rem_q;
    logic [DATA_WIDTH-1:0]    div_rem_d;
    logic [GW-1:0]            div_quo_q;
    logic [GW-1:0]            div_quo_d;
    logic [CNT_W-1:0]         div_cnt_q;
    logic [DATA_WIDTH:0]      div_trial_s;
    logic [DATA_WIDTH-1:0]    div_diff_s;

    logic                     s1_valid_q;
    logic                     s1_sof_q;
    logic                     s1_eof_q;
    logic                     s2_valid_q;
    logic                     s2_sof_q;
    logic                     s2_eof_q;
    logic [DATA_WIDTH-1:0]    s2_pix_q;
    logic [PW-1:0]            s2_prod_q;
    logic                     out_valid_q;
    logic                     out_sof_q;
    logic                     out_eof_q;
    logic [DATA_WIDTH-1:0]    out_data_q;

    logic                     adv_s;
    logic                     issue_s;
    logic                     rd_release_s;
    logic [DATA_WIDTH-1:0]    diff_s;
    logic [PW-1:0]            s2_prod_d;
    logic [PW-1:0]            shift_s;
    logic [DATA_WIDTH-1:0]    stretched_s;
    logic [DATA_WIDTH-1:0]    out_sel_s;

    // Handshake qualifiers and running min/max including the current pixel
    always_comb begin
        in_ready_s   = !full_q[wr_bank_q];
        in_xfer_s    = in_valid && in_ready_s;
        wr_last_s    = in_xfer_s && (wr_addr_q == ADDR_LAST);
        pix_min_s    = (in_data < acc_min_q) ? in_data : acc_min_q;
        pix_max_s    = (in_data > acc_max_q) ? in_data : acc_max_q;
        adv_s        = !out_valid_q || out_ready;
        issue_s      = (state_q == ST_STREAM) && !rd_done_q && adv_s;
        rd_release_s = out_valid_q && out_ready && out_eof_q;
    end

    // Bank full flags: writer sets its bank, reader clears its bank, both may happen at once
    always_comb begin
        full_d = full_q;
        if (wr_last_s) begin
            full_d[wr_bank_q] = 1'b1;
        end else begin
            full_d[wr_bank_q] = full_q[wr_bank_q];
        end
        if (rd_release_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d[rd_bank_q] = full_d[rd_bank_q];
        end
    end

    // Pixel RAM: write port for the writer, registered read port for pipeline stage 1
    always_ff @(posedge clk) begin
        if (in_xfer_s) begin
            mem_q[{wr_bank_q, wr_addr_q}] <= in_data;
        end
        if (issue_s) begin
            ram_rd_q <= mem_q[{rd_bank_q, rd_addr_q}];
        end
    end

    // Writer: address, bank toggling, min/max accumulation and per-bank statistics
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= ADDR_ZERO;
            full_q        <= 2'b00;
            acc_min_q     <= PIX_MAX;
            acc_max_q     <= PIX_ZERO;
            stat_min_q[0] <= PIX_ZERO;
            stat_min_q[1] <= PIX_ZERO;
            stat_max_q[0] <= PIX_ZERO;
            stat_max_q[1] <= PIX_ZERO;
        end else begin
            full_q <= full_d;
            if (in_xfer_s) begin
                wr_addr_q <= wr_addr_q + ADDR_ONE;
                if (wr_last_s) begin
                    stat_min_q[wr_bank_q] <= pix_min_s;
                    stat_max_q[wr_bank_q] <= pix_max_s;
                    acc_min_q             <= PIX_MAX;
                    acc_max_q             <= PIX_ZERO;
                    wr_bank_q             <= !wr_bank_q;
                end else begin
                    acc_min_q <= pix_min_s;
                    acc_max_q <= pix_max_s;
                end
            end
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        div_trial_s = {div_rem_q, div_quo_q[GW-1]};
        div_diff_s  = div_trial_s[DATA_WIDTH-1:0] - div_den_q;
        if (div_trial_s >= {1'b0, div_den_q}) begin
            div_rem_d = div_diff_s;
            div_quo_d = {div_quo_q[GW-2:0], 1'b1};
        end else begin
            div_rem_d = div_trial_s[DATA_WIDTH-1:0];
            div_quo_d = {div_quo_q[GW-2:0], 1'b0};
        end
    end

    // Datapath: offset/multiply for stage 2, shift/clip/mode select for stage 3
    always_comb begin
        diff_s    = ram_rd_q - frame_min_q;
        s2_prod_d = {{(PW-DATA_WIDTH){1'b0}}, diff_s} * {{(PW-GW){1'b0}}, div_quo_q};
        shift_s   = s2_prod_q >> FRAC_BITS;
        if (|shift_s[PW-1:DATA_WIDTH]) begin
            stretched_s = PIX_MAX;
        end else begin
            stretched_s = shift_s[DATA_WIDTH-1:0];
        end
        // A flat frame has no range to stretch, so its pixels pass untouched
        case (mode_q)
            2'd0:    out_sel_s = s2_pix_q;
            2'd2:    out_sel_s = range_zero_q ? s2_pix_q : (PIX_MAX - stretched_s);
            default: out_sel_s = range_zero_q ? s2_pix_q : stretched_s;
        endcase
    end

    // Reader FSM, divider and output pipeline; every stage holds while the sink stalls
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            rd_bank_q    <= 1'b0;
            rd_addr_q    <= ADDR_ZERO;
            rd_done_q    <= 1'b0;
            mode_q       <= 2'd0;
            range_zero_q <= 1'b0;
            frame_min_q  <= PIX_ZERO;
            frame_max_q  <= PIX_ZERO;
            div_den_q    <= PIX_ZERO;
            div_rem_q    <= PIX_ZERO;
            div_quo_q    <= GW_ZERO;
            div_cnt_q    <= CNT_ZERO;
            s1_valid_q   <= 1'b0;
            s1_sof_q     <= 1'b0;
            s1_eof_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sof_q     <= 1'b0;
            s2_eof_q     <= 1'b0;
            s2_pix_q     <= PIX_ZERO;
            s2_prod_q    <= PW_ZERO;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_data_q   <= PIX_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        state_q      <= ST_DIV;
                        mode_q       <= mode;
                        frame_min_q  <= stat_min_q[rd_bank_q];
                        frame_max_q  <= stat_max_q[rd_bank_q];
                        range_zero_q <= (stat_max_q[rd_bank_q] == stat_min_q[rd_bank_q]);
                        div_den_q    <= stat_max_q[rd_bank_q] - stat_min_q[rd_bank_q];
                        div_rem_q    <= PIX_ZERO;
                        div_quo_q    <= DIVIDEND;
                        div_cnt_q    <= CNT_ZERO;
                    end
                end
                ST_DIV: begin
                    // The divider always runs its full length so timing is mode independent
                    div_rem_q <= div_rem_d;
                    div_quo_q <= div_quo_d;
                    div_cnt_q <= div_cnt_q + CNT_ONE;
                    if (div_cnt_q == DIV_LAST) begin
                        state_q   <= ST_STREAM;
                        rd_addr_q <= ADDR_ZERO;
                        rd_done_q <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (issue_s) begin
                        rd_addr_q <= rd_addr_q + ADDR_ONE;
                        if (rd_addr_q == ADDR_LAST) begin
                            rd_done_q <= 1'b1;
                        end
                    end
                    if (rd_release_s) begin
                        state_q   <= ST_IDLE;
                        rd_bank_q <= !rd_bank_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (adv_s) begin
                s1_valid_q  <= issue_s;
                s1_sof_q    <= issue_s && (rd_addr_q == ADDR_ZERO);
                s1_eof_q    <= issue_s && (rd_addr_q == ADDR_LAST);
                s2_valid_q  <= s1_valid_q;
                s2_sof_q    <= s1_sof_q;
                s2_eof_q    <= s1_eof_q;
                out_valid_q <= s2_valid_q;
                out_sof_q   <= s2_sof_q;
                out_eof_q   <= s2_eof_q;
                if (s1_valid_q) begin
                    s2_pix_q  <= ram_rd_q;
                    s2_prod_q <= s2_prod_d;
                end
                if (s2_valid_q) begin
                    out_data_q <= out_sel_s;
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign frame_min = frame_min_q;
    assign frame_max = frame_max_q;

endmodule

// File: tb/tb_gray_stretch_fb.sv
// Scoreboard bench for gray_stretch_fb: a frame-level model predicts every
// output pixel, a monitor compares whatever the DUT presents.
module tb_gray_stretch_fb;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FB = 8;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sof;
    logic          out_eof;
    logic [DW-1:0] frame_min;
    logic [DW-1:0] frame_max;

    gray_stretch_fb #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FRAC_BITS(FB)) dut (
        .clk(clk), .rstn(rstn), .mode(mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof),
        .frame_min(frame_min), .frame_max(frame_max)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic [7:0] mn;
        logic [7:0] mx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] part_q[$];
    int         full_count = 0;
    int         errors = 0;
    int         checks = 0;
    int         stall_cnt = 0;
    bit         rdy_rand = 1'b0;
    logic [7:0] fr [0:N-1];

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: stretch one pixel from the frame's min/max with plain integer math
    function automatic int ref_pix(int p, int mn, int mx, int md);
        int g;
        int r;
        if (md == 0 || mx == mn) return p;
        g = (255 * 256) / (mx - mn);
        r = ((p - mn) * g) >> 8;
        if (r > 255) r = 255;
        if (md == 2) return 255 - r;
        return r;
    endfunction

    // out_ready generator: forced stalls, random, or always ready
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (rdy_rand) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: model the input side, compare every output transfer, check holds under stall
    initial begin
        exp_t       e;
        exp_t       held;
        bit         stall_seen;
        int         mn;
        int         mx;
        stall_seen = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_q.delete();
                part_q.delete();
                full_count = 0;
                stall_seen = 1'b0;
            end else begin
                chk("in_ready", int'(in_ready), int'(full_count < 2));
                if (stall_seen) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_data", int'(out_data), int'(held.d));
                    chk("hold_sof", int'(out_sof), int'(held.sof));
                    chk("hold_eof", int'(out_eof), int'(held.eof));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", int'(out_data), int'(e.d));
                        chk("out_sof", int'(out_sof), int'(e.sof));
                        chk("out_eof", int'(out_eof), int'(e.eof));
                        chk("frame_min", int'(frame_min), int'(e.mn));
                        chk("frame_max", int'(frame_max), int'(e.mx));
                        if (e.eof) full_count--;
                    end
                end
                stall_seen = out_valid && !out_ready;
                held.d   = out_data;
                held.sof = out_sof;
                held.eof = out_eof;
                if (in_valid && in_ready) begin
                    part_q.push_back(in_data);
                    if (part_q.size() == N) begin
                        mn = 255;
                        mx = 0;
                        foreach (part_q[i]) begin
                            if (int'(part_q[i]) < mn) mn = int'(part_q[i]);
                            if (int'(part_q[i]) > mx) mx = int'(part_q[i]);
                        end
                        foreach (part_q[i]) begin
                            e.d   = 8'(ref_pix(int'(part_q[i]), mn, mx, int'(mode)));
                            e.sof = (i == 0);
                            e.eof = (i == N - 1);
                            e.mn  = 8'(mn);
                            e.mx  = 8'(mx);
                            exp_q.push_back(e);
                        end
                        part_q.delete();
                        full_count++;
                    end
                end
            end
        end
    end

    // Offer one pixel; called and returning at posedge+1
    task automatic send(input logic [7:0] p, output int waits);
        bit acc;
        waits = 0;
        in_valid = 1'b1;
        in_data  = p;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
            waits++;
        end
        chk("send_timeout", 1, 0);
    endtask

    task automatic send_frame(input bit gaps);
        int w;
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send(fr[i], w);
        end
        in_valid = 1'b0;
    endtask

    // First out_valid counted from the edge of the last input transfer:
    // one cycle for the full flag to reach the reader, then divider + pipeline
    task automatic measure_latency();
        int lat;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("first_out_latency", lat, 1 + DW + FB + 3);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && part_q.size() == 0 && full_count == 0) break;
        end
        if (k == 1000) chk("drain_timeout", 1, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int pix33_wait;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sof", int'(out_sof), 0);
        chk("rst_out_eof", int'(out_eof), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_frame_min", int'(frame_min), 0);
        chk("rst_frame_max", int'(frame_max), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Mode 1 ramp 10..25: gain 4352, outputs step by 17
        mode = 2'd1;
        for (int i = 0; i < N; i++) fr[i] = 8'(10 + i);
        send_frame(1'b0);
        measure_latency();
        drain();

        // Mode 2 ramp: inverted stretch
        mode = 2'd2;
        send_frame(1'b0);
        drain();

        // Mode 1 flat frame: range zero passes pixels unchanged
        mode = 2'd1;
        for (int i = 0; i < N; i++) fr[i] = 8'd100;
        send_frame(1'b0);
        drain();

        // Mode 0 random frame with latency check
        mode = 2'd0;
        for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(0, 255));
        send_frame(1'b0);
        measure_latency();
        drain();

        // Mode 3 behaves as mode 1
        mode = 2'd3;
        for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(40, 90));
        send_frame(1'b0);
        drain();

        // Continuous input, 4 frames, 5-cycle stall during first output frame
        mode = 2'd1;
        pix33_wait = 0;
        fork
            begin
                for (int i = 0; i < 4 * N; i++) begin
                    send(8'($urandom_range(0, 255)), w);
                    if (i == 32) pix33_wait = w;
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                repeat (4) @(negedge clk);
                stall_cnt = 5;
            end
        join
        chk("pix33_blocked", int'(pix33_wait > 0), 1);
        drain();

        // Reset in the middle of streaming, then a clean ramp frame
        mode = 2'd1;
        for (int i = 0; i < N; i++) fr[i] = 8'(10 + i);
        send_frame(1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_frame_min", int'(frame_min), 0);
        send_frame(1'b0);
        drain();

        // Random frames, random modes, random gaps and backpressure
        rdy_rand = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int lo;
            int hi;
            mode = 2'($urandom_range(0, 3));
            lo = $urandom_range(0, 200);
            hi = lo + $urandom_range(0, 255 - lo);
            for (int i = 0; i < N; i++) fr[i] = 8'($urandom_range(lo, hi));
            send_frame(1'b1);
            send_frame(1'b1);
            drain();
        end
        rdy_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        chk("watchdog_timeout", 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
